// File: rtl/minterm_lut_engine.sv
// Programmable N_IN-input Boolean function held as a minterm mask, with a
// registered evaluation path, a serial mask loader and a minterm-count sweep.
module minterm_lut_engine #(
  parameter int                    N_IN         = 4,
  parameter logic [(1<<N_IN)-1:0]  DEFAULT_MASK = 16'h030B
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] a,
  input  logic            a_valid,
  output logic            q,
  output logic            q_valid,
  input  logic            load_start,
  input  logic            load_bit,
  output logic            load_busy,
  input  logic            sweep_start,
  output logic            sweep_busy,
  output logic            sweep_done,
  output logic [N_IN:0]   minterm_count
);

  localparam int MW = 1 << N_IN;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SWEEP = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [MW-1:0]   mask;
  logic [MW-1:0]   shadow;
  logic [N_IN-1:0] idx;
  logic [N_IN:0]   acc;
  logic [N_IN:0]   acc_sum;
  logic            idx_last;

  assign idx_last = (idx == {N_IN{1'b1}});
  // acc is one bit wider than idx so a full mask counts to MW instead of wrapping.
  assign acc_sum  = acc + {{N_IN{1'b0}}, mask[idx]};

  // NOTE: every signal written in always_comb gets a default first; a path that
  // leaves it unassigned would infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (load_start)       state_next = LOAD;
        else if (sweep_start) state_next = SWEEP;
      end
      LOAD:    if (idx_last) state_next = IDLE;
      SWEEP:   if (idx_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: mask and shadow are plain registers, not a RAM, so they can be reset
  // in the same synchronous branch as the control flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask          <= DEFAULT_MASK;
      shadow        <= '0;
      idx           <= '0;
      acc           <= '0;
      q             <= 1'b0;
      q_valid       <= 1'b0;
      load_busy     <= 1'b0;
      sweep_busy    <= 1'b0;
      sweep_done    <= 1'b0;
      minterm_count <= '0;
    end else begin
      if (a_valid) q <= mask[a];
      q_valid    <= a_valid;
      sweep_done <= 1'b0;
      load_busy  <= (state_next == LOAD);
      sweep_busy <= (state_next == SWEEP);

      unique case (state)
        LOAD: begin
          shadow[idx] <= load_bit;
          if (idx_last) begin
            // Commit the whole new mask in one edge; evaluation never sees a partial one.
            mask <= {load_bit, shadow[MW-2:0]};
            idx  <= '0;
          end else begin
            idx  <= idx + N_IN'(1);
          end
        end
        SWEEP: begin
          if (idx_last) begin
            minterm_count <= acc_sum;
            sweep_done    <= 1'b1;
            acc           <= '0;
            idx           <= '0;
          end else begin
            acc <= acc_sum;
            idx <= idx + N_IN'(1);
          end
        end
        default: begin
          idx <= '0;
          acc <= '0;
        end
      endcase
    end
  end

endmodule
